// File: rtl/dmem_if.sv
// dmem_if: CPU data-memory request/response bundle.
// The byte_en lane mask exists only when DMEM_BYTE_WRITE_EN is defined.
interface dmem_if #(parameter int ADDR_W = 8);
  logic              enable;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       data_in;
  logic              ready;
  logic [15:0]       data_out;
  logic              data_valid;
`ifdef DMEM_BYTE_WRITE_EN
  logic [1:0]        byte_en;
  modport master (output enable, wr, addr, data_in, byte_en, input ready, data_out, data_valid);
  modport slave  (input enable, wr, addr, data_in, byte_en, output ready, data_out, data_valid);
`else
  modport master (output enable, wr, addr, data_in, input ready, data_out, data_valid);
  modport slave  (input enable, wr, addr, data_in, output ready, data_out, data_valid);
`endif
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: pipelined data-memory responder that self-clears its storage after reset.
// Optional byte-lane writes are enabled by defining DMEM_BYTE_WRITE_EN.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {INIT, RUN} state_t;
  state_t                   r_state;
  logic [ADDR_W-1:0]        r_clr;
  logic [15:0]              r_mem [DEPTH];
  logic [LATENCY-1:0]       r_vld;
  logic [LATENCY-1:0][15:0] r_dat;
  logic                     w_run;
  logic                     w_rd;
  logic                     w_wr;
  logic [15:0]              w_wdata;
  generate
    if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 1..8");
    end
  endgenerate
  assign w_run = r_state == RUN;
  assign w_rd  = bus.enable & ~bus.wr & w_run;
  assign w_wr  = bus.enable & bus.wr & w_run;
`ifdef DMEM_BYTE_WRITE_EN
  assign w_wdata = {bus.byte_en[1] ? bus.data_in[15:8] : r_mem[bus.addr][15:8],
                    bus.byte_en[0] ? bus.data_in[7:0]  : r_mem[bus.addr][7:0]};
`else
  assign w_wdata = bus.data_in;
`endif
  assign bus.ready      = w_run;
  assign bus.data_valid = r_vld[LATENCY-1];
  assign bus.data_out   = r_dat[LATENCY-1];
  // Storage has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk)
    if (!w_run) r_mem[r_clr] <= '0;
    else if (w_wr) r_mem[bus.addr] <= w_wdata;
  // Each stage's data only advances with its valid bit, so data_out holds between responses.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= INIT;
      r_clr   <= '0;
      r_vld   <= '0;
      r_dat   <= '0;
    end else begin
      if (!w_run) begin
        r_clr <= r_clr + ADDR_W'(1);
        if (&r_clr) r_state <= RUN;
      end
      r_vld <= LATENCY'({r_vld, w_rd});
      if (w_rd) r_dat[0] <= r_mem[bus.addr];
      for (int i = 1; i < LATENCY; i++)
        if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench with a reference model of the responder's behaviour.
module tb_dmem_responder;
  localparam int ADDR_W = 8;
  localparam int LAT    = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef struct {
    int          due;
    logic [15:0] d;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [15:0] m_mem [DEPTH];
  rsp_t        exp_q [$];
  int          since_rel = 0;
  logic [15:0] exp_last  = '0;
  logic [1:0]  be_eff;

  dmem_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef DMEM_BYTE_WRITE_EN
  assign be_eff = bus.byte_en;
`else
  assign be_eff = 2'b11;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                        input logic [1:0] b);
    logic [15:0] r;
    r = old;
    for (int i = 0; i < 2; i++)
      if (b[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  // Reference model: ready after DEPTH post-reset cycles, reads due LAT cycles later.
  always @(posedge clk or posedge rst)
    if (rst) begin
      since_rel <= 0;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] <= '0;
    end else begin
      since_rel <= since_rel + 1;
      if (bus.enable && since_rel >= DEPTH) begin
        if (bus.wr) m_mem[bus.addr] <= merge(m_mem[bus.addr], bus.data_in, be_eff);
        else exp_q.push_back('{due: since_rel + LAT, d: m_mem[bus.addr]});
      end
    end

  always @(negedge clk) begin
    logic exp_v;
    #1;
    exp_v = 1'b0;
    if (rst) exp_last = '0;
    else if (exp_q.size() > 0 && exp_q[0].due == since_rel) begin
      exp_v    = 1'b1;
      exp_last = exp_q[0].d;
      exp_q.pop_front();
    end
    chk("cmp_ready", 32'(bus.ready), 32'(!rst && since_rel >= DEPTH));
    chk("cmp_valid", 32'(bus.data_valid), 32'(exp_v));
    chk("cmp_dout", 32'(bus.data_out), 32'(exp_last));
  end

  task automatic req(input logic w, input logic [ADDR_W-1:0] a, input logic [15:0] d,
                     input logic [1:0] be);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
`ifdef DMEM_BYTE_WRITE_EN
    bus.byte_en = be;
`endif
  endtask

  task automatic idle();
    @(negedge clk);
    bus.enable = 1'b0;
    bus.wr     = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    #2;
    for (k = 0; k < 12 && !bus.data_valid; k++) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic rd_chk(input logic [ADDR_W-1:0] a, input logic [15:0] exp, input string nm);
    int k;
    req(1'b0, a, 16'h0, 2'b11);
    idle();
    wait_valid(k);
    if (k == 12) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_lat"}, 32'(k + 1), 32'(LAT));
      chk(nm, 32'(bus.data_out), 32'(exp));
      @(negedge clk);
      #2;
      chk({nm, "_pulse"}, 32'(bus.data_valid), 32'd0);
    end
  endtask

  // Releases reset, drops a write issued during INIT, and measures INIT length.
  task automatic release_and_init(input string nm);
    int n;
    rst = 1'b0;
    n   = 0;
    while (!bus.ready && n < 400) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        bus.enable  = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = 8'h05;
        bus.data_in = 16'h1234;
      end else if (n == 6) bus.enable = 1'b0;
    end
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    int k;
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
`ifdef DMEM_BYTE_WRITE_EN
    bus.byte_en = 2'b11;
`endif
    repeat (3) @(negedge clk);
    #2;
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_valid", 32'(bus.data_valid), 32'd0);
    chk("rst_dout", 32'(bus.data_out), 32'd0);
    @(negedge clk);
    release_and_init("init_len");
    rd_chk(8'h3C, 16'h0000, "rd_cleared");
    rd_chk(8'h05, 16'h0000, "rd_dropped");
    req(1'b1, 8'h10, 16'hBEEF, 2'b11);
    rd_chk(8'h10, 16'hBEEF, "rd_beef");
    for (int i = 0; i < 4; i++) req(1'b1, ADDR_W'(i), 16'(i + 1), 2'b11);
    for (int i = 0; i < 4; i++) req(1'b0, ADDR_W'(i), 16'h0, 2'b11);
    idle();
    wait_valid(k);
    chk("stream_start", 32'(k < 12), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("stream_valid", 32'(bus.data_valid), 32'd1);
      chk("stream_data", 32'(bus.data_out), 32'(i + 1));
      @(negedge clk);
      #2;
    end
    chk("stream_end", 32'(bus.data_valid), 32'd0);
    repeat (3) @(negedge clk);
    #2;
    chk("dout_hold", 32'(bus.data_out), 32'h0004);
    req(1'b1, 8'hFF, 16'hF00D, 2'b11);
    idle();
    rd_chk(8'hFF, 16'hF00D, "rd_top");
    rd_chk(8'h00, 16'h0001, "rd_bottom");
`ifdef DMEM_BYTE_WRITE_EN
    req(1'b1, 8'h20, 16'hAAAA, 2'b11);
    req(1'b1, 8'h20, 16'h5555, 2'b01);
    rd_chk(8'h20, 16'hAA55, "be_low");
    req(1'b1, 8'h20, 16'h1234, 2'b00);
    rd_chk(8'h20, 16'hAA55, "be_none");
    req(1'b1, 8'h20, 16'h1234, 2'b10);
    rd_chk(8'h20, 16'h1255, "be_high");
`endif
    req(1'b0, 8'h01, 16'h0, 2'b11);
    req(1'b0, 8'h02, 16'h0, 2'b11);
    @(negedge clk);
    bus.enable = 1'b0;
    rst        = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("flight_valid", 32'(bus.data_valid), 32'd0);
      chk("flight_ready", 32'(bus.ready), 32'd0);
      @(negedge clk);
    end
    release_and_init("reinit_len");
    rd_chk(8'h10, 16'h0000, "rd_reinit_beef");
    rd_chk(8'h02, 16'h0000, "rd_reinit_stream");
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
